wshb_mire_writer: RTL



---
 rtl/mire_pkg.sv | 42 ++++
 rtl/wshb_mire_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mire_pkg.sv
// mire_pkg -- shared types and helpers for the framebuffer test-pattern writer.
//
// Contents:
//   state_t     : writer FSM states (IDLE, WRITE, HOLD)
//   WHITE       : colour of the grid lines and the frame border (0x00RRGGBB)
//   BLUE_LEVEL  : constant blue component used inside the grid cells
//   pix()       : pattern colour for pixel (x, y) of an hdisp x vdisp frame,
//                 with grid lines every 2**grid pixels
package mire_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] WHITE      = 32'h00FF_FFFF;
    localparam logic [7:0]  BLUE_LEVEL = 8'h80;

    // Grid lines where the low 'grid' bits of x or y are zero, plus a one-pixel
    // border on the right and bottom edges. Inside the cells red follows x and
    // green follows y, so a misplaced pixel is easy to spot on screen.
    function automatic logic [31:0] pix(
        input logic [31:0] x,
        input logic [31:0] y,
        input int          hdisp,
        input int          vdisp,
        input int          grid
    );
        logic [31:0] mask;
        logic [31:0] result;
        mask = (32'd1 << grid) - 32'd1;
        if (((x & mask) == 32'd0) || ((y & mask) == 32'd0) ||
            (x == 32'(hdisp - 1)) || (y == 32'(vdisp - 1))) begin
            result = WHITE;
        end else begin
            result = {8'h00, x[7:0], y[7:0], BLUE_LEVEL};
        end
        return result;
    endfunction

endpackage

// File: rtl/wshb_mire_writer.sv
// wshb_mire_writer -- Wishbone master that paints a test pattern into the
// SDRAM framebuffer read by the VGA reader (one 32-bit 0x00RRGGBB word per
// pixel at byte address 4*(y*HDISP+x)).
//
// Writes are issued as classic Wishbone cycles in bursts of at most BURST
// accepted writes; cyc is then dropped for PAUSE cycles so the arbiter can
// hand the bus to the VGA reader.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle request to write one full frame (ignored while busy)
//   busy          : frame in progress
//   done          : one-cycle pulse after the last write was acknowledged
//   wshb_*        : Wishbone master interface (write-only; wshb_dat_sm unused)
module wshb_mire_writer
    import mire_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64,
    parameter int PAUSE = 16,
    parameter int GRID  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic        wshb_we,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    input  logic [31:0] wshb_dat_sm
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = $clog2(BURST + 1);
    localparam int PW = $clog2(PAUSE + 1);

    localparam logic [XW-1:0] X_LAST     = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(VDISP - 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST - 1);
    localparam logic [PW-1:0] PAUSE_INIT = PW'(PAUSE);

    state_t         state_reg, state_next;
    logic [XW-1:0]  x_reg, x_next;
    logic [YW-1:0]  y_reg, y_next;
    logic [BW-1:0]  beat_reg, beat_next;
    logic [PW-1:0]  pause_reg, pause_next;
    logic [31:0]    adr_reg, adr_next;
    logic [31:0]    dat_reg, dat_next;
    logic           cyc_reg, cyc_next;
    logic           stb_reg, stb_next;
    logic           we_reg, we_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;

    // Coordinates of the pixel following the current one (raster order).
    logic [XW-1:0]  x_adv;
    logic [YW-1:0]  y_adv;
    logic           last_pix;
    logic           burst_end;
    logic           accept_start;

    // The done cycle still belongs to the finishing frame, so a start seen
    // then is dropped just like one seen while busy.
    assign accept_start = start && !done_reg;
    assign last_pix     = (x_reg == X_LAST) && (y_reg == Y_LAST);
    assign burst_end    = (beat_reg == BEAT_LAST);

    always_comb begin
        x_adv = x_reg + XW'(1);
        y_adv = y_reg;
        if (x_reg == X_LAST) begin
            x_adv = '0;
            y_adv = y_reg + YW'(1);
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            beat_reg  <= '0;
            pause_reg <= '0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            beat_reg  <= beat_next;
            pause_reg <= pause_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            cyc_reg   <= cyc_next;
            stb_reg   <= stb_next;
            we_reg    <= we_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_start) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // Frame completion takes priority over the burst limit.
                if (wshb_ack) begin
                    if (last_pix) begin
                        state_next = IDLE;
                    end else if (burst_end) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (pause_reg == PW'(1)) begin
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of counters and registered outputs. Everything holds by
    // default, which keeps adr/dat stable while a write waits for ack.
    always_comb begin
        x_next     = x_reg;
        y_next     = y_reg;
        beat_next  = beat_reg;
        pause_next = pause_reg;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        cyc_next   = cyc_reg;
        stb_next   = stb_reg;
        we_next    = we_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept_start) begin
                    x_next    = '0;
                    y_next    = '0;
                    beat_next = '0;
                    adr_next  = '0;
                    dat_next  = pix(32'd0, 32'd0, HDISP, VDISP, GRID);
                    cyc_next  = 1'b1;
                    stb_next  = 1'b1;
                    we_next   = 1'b1;
                    busy_next = 1'b1;
                end
            end
            WRITE: begin
                if (wshb_ack) begin
                    if (last_pix) begin
                        cyc_next  = 1'b0;
                        stb_next  = 1'b0;
                        we_next   = 1'b0;
                        adr_next  = '0;
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        x_next    = x_adv;
                        y_next    = y_adv;
                        adr_next  = adr_reg + 32'd4;
                        dat_next  = pix(32'(x_adv), 32'(y_adv), HDISP, VDISP, GRID);
                        beat_next = beat_reg + BW'(1);
                        if (burst_end) begin
                            cyc_next   = 1'b0;
                            stb_next   = 1'b0;
                            we_next    = 1'b0;
                            beat_next  = '0;
                            pause_next = PAUSE_INIT;
                        end
                    end
                end
            end
            HOLD: begin
                pause_next = pause_reg - PW'(1);
                if (pause_reg == PW'(1)) begin
                    cyc_next = 1'b1;
                    stb_next = 1'b1;
                    we_next  = 1'b1;
                end
            end
            default: begin
                cyc_next  = 1'b0;
                stb_next  = 1'b0;
                we_next   = 1'b0;
                busy_next = 1'b0;
            end
        endcase
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign wshb_adr    = adr_reg;
    assign wshb_dat_ms = dat_reg;
    assign wshb_cyc    = cyc_reg;
    assign wshb_stb    = stb_reg;
    assign wshb_we     = we_reg;
    // Classic single cycles only, all four bytes written.
    assign wshb_sel    = 4'b1111;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;

    // Read data is never used by a write-only master.
    logic unused_dat_sm;
    assign unused_dat_sm = ^wshb_dat_sm;

endmodule
